// File: rtl/cpu_types_pkg.sv
// Shared CPU types: data word, register-file geometry and the register dumper FSM encoding.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    localparam int unsigned NUM_REGS  = 32;
    localparam int unsigned REG_IDX_W = 5;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        SEND,
        DONE
    } dump_state_t;

endpackage

// File: rtl/regfile_dumper.sv
// Walks every register-file entry once per start, presenting each word on a
// valid/ready stream and accumulating an XOR checksum of the accepted words.
module regfile_dumper
    import cpu_types_pkg::*;
#(
    parameter int unsigned NREGS = NUM_REGS,
    parameter int unsigned IDXW  = REG_IDX_W
) (
    input  logic            CLK,
    input  logic            nRst,
    input  logic            start,
    output logic [IDXW-1:0] rsel,
    input  word_t           rdat,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [IDXW-1:0] out_idx,
    output word_t           out_data,
    output logic            busy,
    output logic            done,
    output word_t           checksum
);

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NREGS - 1);

    dump_state_t     state_q, state_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic [IDXW-1:0] out_idx_q, out_idx_d;
    word_t           out_data_q, out_data_d;
    word_t           checksum_q, checksum_d;

    logic xfer;
    logic last_idx;

    assign xfer     = (state_q == SEND) && out_ready;
    assign last_idx = (idx_q == LAST_IDX);

    always_ff @(posedge CLK or posedge nRst) begin
        if (nRst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = READ;
            READ:    state_d = SEND;
            SEND:    if (xfer) state_d = last_idx ? DONE : READ;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // idx is returned to 0 on leaving DONE so rsel reads 0 throughout IDLE.
    always_comb begin
        idx_d      = idx_q;
        out_idx_d  = out_idx_q;
        out_data_d = out_data_q;
        checksum_d = checksum_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    idx_d      = '0;
                    checksum_d = '0;
                end
            end
            READ: begin
                out_data_d = rdat;
                out_idx_d  = idx_q;
            end
            SEND: begin
                if (xfer) begin
                    checksum_d = checksum_q ^ out_data_q;
                    if (!last_idx) begin
                        idx_d = idx_q + IDXW'(1);
                    end
                end
            end
            DONE: begin
                idx_d = '0;
            end
            default: begin
                idx_d = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge nRst) begin
        if (nRst) begin
            idx_q      <= '0;
            out_idx_q  <= '0;
            out_data_q <= '0;
            checksum_q <= '0;
        end else begin
            idx_q      <= idx_d;
            out_idx_q  <= out_idx_d;
            out_data_q <= out_data_d;
            checksum_q <= checksum_d;
        end
    end

    assign rsel      = idx_q;
    assign out_valid = (state_q == SEND);
    assign out_idx   = out_idx_q;
    assign out_data  = out_data_q;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign checksum  = checksum_q;

endmodule

// File: tb/tb_regfile_dumper.sv
// Directed bench for regfile_dumper with a behavioural register file on rsel/rdat.
`timescale 1ns/1ps
module tb_regfile_dumper;
    import cpu_types_pkg::*;

    localparam int unsigned NR = 32;

    logic       CLK = 1'b0;
    logic       nRst;
    logic       start;
    logic [4:0] rsel;
    word_t      rdat;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] out_idx;
    word_t      out_data;
    logic       busy;
    logic       done;
    word_t      checksum;

    word_t regs     [NR];
    word_t cap_data [NR];

    int unsigned n_checks    = 0;
    int unsigned n_fail      = 0;
    int unsigned done_pulses = 0;

    always #5 CLK = ~CLK;

    // Register 0 is hardwired to zero, as in the CPU register file.
    assign rdat = (rsel == 5'd0) ? '0 : regs[rsel];

    always @(negedge CLK) begin
        if (done) done_pulses <= done_pulses + 1;
    end

    regfile_dumper #(
        .NREGS(32),
        .IDXW (5)
    ) dut (
        .CLK      (CLK),
        .nRst     (nRst),
        .start    (start),
        .rsel     (rsel),
        .rdat     (rdat),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_idx  (out_idx),
        .out_data (out_data),
        .busy     (busy),
        .done     (done),
        .checksum (checksum)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    function automatic word_t exp_word(input int unsigned i);
        return (i == 0) ? '0 : regs[i];
    endfunction

    task automatic load_mul();
        for (int n = 0; n < NR; n++) regs[n] = word_t'(n) * 32'h11111111;
    endtask

    task automatic load_onehot();
        for (int n = 0; n < NR; n++) regs[n] = word_t'(1) << n;
    endtask

    // scen: 0 = ready held high, 1 = ready pattern 1,0,0, 2 = stray starts, 3 = write during READ
    task automatic run_scan(input int unsigned scen, output word_t csum_exp);
        int unsigned n_xfer, cyc, ph, pulses_before;
        logic        seen_done, holding;
        word_t       held_exp;
        n_xfer = 0; cyc = 0; ph = 0;
        seen_done = 1'b0; holding = 1'b0;
        held_exp = '0; csum_exp = '0;
        pulses_before = done_pulses;
        start = 1'b1; out_ready = 1'b1;
        step();
        start = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
        check("csum_cleared", checksum, 32'd0);
        while (!seen_done && cyc < 8 * NR) begin
            start = 1'b0;
            if (done) begin
                seen_done = 1'b1;
                if (scen != 1) check("done_cycle", cyc, 2 * NR);
                check("xfer_count", n_xfer, NR);
                check("csum_at_done", checksum, csum_exp);
                check("rsel_in_done", 32'(rsel), NR - 1);
                check("valid_in_done", 32'(out_valid), 32'd0);
                if (scen == 2) start = 1'b1;
            end else if (out_valid) begin
                if (holding) begin
                    check("hold_data", out_data, held_exp);
                    check("hold_idx", 32'(out_idx), n_xfer);
                    if (scen == 3 && n_xfer == 7) regs[7] = 32'h12345678;
                end else begin
                    held_exp = exp_word(n_xfer);
                    check("word_idx", 32'(out_idx), n_xfer);
                    check("word_data", out_data, held_exp);
                    cap_data[n_xfer] = out_data;
                    holding = 1'b1;
                end
                check("rsel_in_send", 32'(rsel), n_xfer);
                if (scen == 2 && n_xfer == 3) start = 1'b1;
                out_ready = (scen == 1) ? (ph % 3 == 0) : 1'b1;
                ph++;
                if (out_ready) begin
                    csum_exp ^= held_exp;
                    n_xfer++;
                    holding = 1'b0;
                end
            end else begin
                check("rsel_in_read", 32'(rsel), n_xfer);
                if (scen == 3 && n_xfer == 7) regs[7] = 32'hDEADBEEF;
            end
            step();
            cyc++;
        end
        if (!seen_done) check("scan_timeout", 32'd0, 32'd1);
        start = 1'b0;
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_done", 32'(done), 32'd0);
        check("idle_rsel", 32'(rsel), 32'd0);
        check("idle_csum", checksum, csum_exp);
        repeat (3) step();
        check("idle_still", 32'(busy), 32'd0);
        check("csum_hold", checksum, csum_exp);
        check("done_pulses", done_pulses - pulses_before, 32'd1);
    endtask

    initial begin
        word_t cs0, cs;
        int unsigned n, cyc, pulses_before;
        nRst = 1'b1; start = 1'b0; out_ready = 1'b0;
        for (int i = 0; i < NR; i++) begin
            regs[i] = '0;
            cap_data[i] = '0;
        end
        #2;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_rsel", 32'(rsel), 32'd0);
        check("rst_out_idx", 32'(out_idx), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_csum", checksum, 32'd0);
        repeat (2) step();
        nRst = 1'b0;
        step();
        check("idle_no_start", 32'(busy), 32'd0);

        load_mul();
        run_scan(0, cs0);
        check("data0", cap_data[0], 32'h00000000);
        check("data5", cap_data[5], 32'h55555555);
        check("data31", cap_data[31], 32'h1111110F);

        run_scan(1, cs);
        check("csum_toggle", checksum, cs0);

        load_onehot();
        run_scan(0, cs);
        check("csum_onehot", checksum, 32'hFFFFFFFE);

        load_mul();
        run_scan(2, cs);

        load_mul();
        run_scan(3, cs);
        check("data7_late_write", cap_data[7], 32'hDEADBEEF);

        load_mul();
        pulses_before = done_pulses;
        start = 1'b1; out_ready = 1'b1;
        step();
        start = 1'b0;
        n = 0; cyc = 0;
        while (!(out_valid && n == 10) && cyc < 100) begin
            if (out_valid) n++;
            step();
            cyc++;
        end
        check("abort_reached", n, 32'd10);
        check("abort_at_idx", 32'(out_idx), 32'd10);
        #2;
        nRst = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_valid", 32'(out_valid), 32'd0);
        check("abort_rsel", 32'(rsel), 32'd0);
        check("abort_out_idx", 32'(out_idx), 32'd0);
        check("abort_out_data", out_data, 32'd0);
        check("abort_csum", checksum, 32'd0);
        repeat (2) step();
        nRst = 1'b0;
        repeat (3) step();
        check("abort_no_done", done_pulses - pulses_before, 32'd0);
        check("abort_idle", 32'(busy), 32'd0);
        run_scan(0, cs);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
